// File: rtl/micro_sequencer_if.sv
// Bus between the picoRISC control store / datapath and the micro-sequencer:
// microinstruction fields and status in, control-store address and state out.
interface micro_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int COND_W = 8
);
    localparam int SEL_W = (COND_W > 1) ? $clog2(COND_W) : 1;

    logic              start;
    logic [1:0]        mi_br_type;
    logic [ADDR_W-1:0] mi_target;
    logic [SEL_W-1:0]  mi_cond_sel;
    logic              mi_cond_neg;
    logic [COND_W-1:0] cond;
    logic [ADDR_W-1:0] mbr_addr;
    logic              mem_wait;
    logic              halt_req;
    logic [ADDR_W-1:0] upc;
    logic              upc_valid;
    logic              halted;

    modport master (
        output start, mi_br_type, mi_target, mi_cond_sel, mi_cond_neg,
               cond, mbr_addr, mem_wait, halt_req,
        input  upc, upc_valid, halted
    );

    modport slave (
        input  start, mi_br_type, mi_target, mi_cond_sel, mi_cond_neg,
               cond, mbr_addr, mem_wait, halt_req,
        output upc, upc_valid, halted
    );
endinterface

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: owns the uPC and selects the next control-store
// address from increment, jump, conditional jump or the multiway encoder.
module micro_sequencer #(
    parameter int ADDR_W = 8,
    parameter int COND_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    micro_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [1:0] BR_NEXT  = 2'b00;
    localparam logic [1:0] BR_JUMP  = 2'b01;
    localparam logic [1:0] BR_COND  = 2'b10;
    localparam logic [1:0] BR_MULTI = 2'b11;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] upc;
    logic [ADDR_W-1:0] upc_next;
    logic [ADDR_W-1:0] upc_inc;
    logic [COND_W-1:0] cond_vec;
    logic              cond_taken;

    assign cond_vec   = bus.cond;
    assign cond_taken = cond_vec[bus.mi_cond_sel] ^ bus.mi_cond_neg;
    assign upc_inc    = upc + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            upc   <= '0;
        end else begin
            state <= state_next;
            upc   <= upc_next;
        end
    end

    // A stall freezes everything, including a pending halt request.
    always_comb begin
        state_next = state;
        upc_next   = upc;
        case (state)
            IDLE: begin
                upc_next = '0;
                if (bus.start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!bus.mem_wait) begin
                    if (bus.halt_req) begin
                        state_next = HALT;
                    end else begin
                        case (bus.mi_br_type)
                            BR_NEXT:  upc_next = upc_inc;
                            BR_JUMP:  upc_next = bus.mi_target;
                            BR_COND:  upc_next = cond_taken ? bus.mi_target : upc_inc;
                            BR_MULTI: upc_next = bus.mbr_addr;
                            default:  upc_next = upc_inc;
                        endcase
                    end
                end
            end
            HALT: begin
                if (bus.start) begin
                    state_next = RUN;
                    upc_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                upc_next   = '0;
            end
        endcase
    end

    assign bus.upc       = upc;
    assign bus.upc_valid = (state == RUN);
    assign bus.halted    = (state == HALT);
endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the uPC.
module tb_micro_sequencer;
    localparam int ADDR_W = 8;
    localparam int COND_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    micro_sequencer_if #(.ADDR_W(ADDR_W), .COND_W(COND_W)) bus ();

    micro_sequencer #(.ADDR_W(ADDR_W), .COND_W(COND_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: running / halted flags plus the address as a plain integer.
    bit m_running;
    bit m_halted;
    int m_upc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int taken;
        if (!rst_n) begin
            m_running = 1'b0;
            m_halted  = 1'b0;
            m_upc     = 0;
        end else if (m_halted) begin
            if (bus.start) begin
                m_halted  = 1'b0;
                m_running = 1'b1;
                m_upc     = 0;
            end
        end else if (!m_running) begin
            if (bus.start) m_running = 1'b1;
            m_upc = 0;
        end else if (!bus.mem_wait) begin
            if (bus.halt_req) begin
                m_running = 1'b0;
                m_halted  = 1'b1;
            end else begin
                case (int'(bus.mi_br_type))
                    0: m_upc = (m_upc + 1) % 256;
                    1: m_upc = int'(bus.mi_target);
                    2: begin
                        taken = (int'(bus.cond) >> int'(bus.mi_cond_sel)) & 1;
                        if (taken != int'(bus.mi_cond_neg)) m_upc = int'(bus.mi_target);
                        else m_upc = (m_upc + 1) % 256;
                    end
                    default: m_upc = int'(bus.mbr_addr);
                endcase
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_stimulus(input bit st, input int bt, input int tgt, input int sel,
                                  input int neg, input int cnd, input int mbr,
                                  input bit mw, input bit hr);
        bus.start       = st;
        bus.mi_br_type  = bt[1:0];
        bus.mi_target   = tgt[7:0];
        bus.mi_cond_sel = sel[2:0];
        bus.mi_cond_neg = neg[0];
        bus.cond        = cnd[7:0];
        bus.mbr_addr    = mbr[7:0];
        bus.mem_wait    = mw;
        bus.halt_req    = hr;
    endtask

    task automatic check_output(input string tag);
        check({tag, ".upc"},       32'(bus.upc),       m_upc);
        check({tag, ".upc_valid"}, 32'(bus.upc_valid), 32'(m_running));
        check({tag, ".halted"},    32'(bus.halted),    32'(m_halted));
    endtask

    task automatic start_run();
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic goto_addr(input int addr);
        apply_stimulus(0, 1, addr, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    initial begin
        m_running = 1'b0;
        m_halted  = 1'b0;
        m_upc     = 0;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        check_output("reset");
        rst_n = 1'b1;

        // Reset mid-run, with start asserted across the reset edge
        start_run();
        check_output("start");
        check("start.upc0", 32'(bus.upc), 32'd0);
        goto_addr(8'h2A);
        check_output("pre_reset");
        rst_n = 1'b0;
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check_output("mid_reset");
        check("mid_reset.valid0", 32'(bus.upc_valid), 32'd0);
        rst_n = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check_output("post_reset_idle");

        // Sequential run with wrap 255 -> 0
        start_run();
        for (int i = 0; i < 299; i++) begin
            step();
            check_output("seq");
        end
        check("seq.end43", 32'(bus.upc), 32'd43);

        // Conditional branch: taken, inverted-not-taken, inverted-taken
        goto_addr(5);
        apply_stimulus(0, 2, 8'h40, 3, 0, 8'h08, 0, 0, 0);
        step();
        check_output("cond_taken");
        check("cond_taken.abs", 32'(bus.upc), 32'h40);
        goto_addr(5);
        apply_stimulus(0, 2, 8'h40, 3, 1, 8'h08, 0, 0, 0);
        step();
        check_output("cond_neg_fall");
        check("cond_neg_fall.abs", 32'(bus.upc), 32'd6);
        goto_addr(5);
        apply_stimulus(0, 2, 8'h40, 3, 1, 8'h00, 0, 0, 0);
        step();
        check_output("cond_neg_taken");

        // Multiway branch, zero target, stalled multiway
        goto_addr(3);
        apply_stimulus(0, 3, 0, 0, 0, 0, 17, 0, 0);
        step();
        check_output("mbr17");
        goto_addr(3);
        apply_stimulus(0, 3, 0, 0, 0, 0, 0, 0, 0);
        step();
        check_output("mbr0");
        goto_addr(3);
        apply_stimulus(0, 3, 0, 0, 0, 0, 49, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("mbr_stall");
            check("mbr_stall.abs", 32'(bus.upc), 32'd3);
        end
        apply_stimulus(0, 3, 0, 0, 0, 0, 49, 0, 0);
        step();
        check_output("mbr49");

        // Halt priority, halt under stall, restart from HALT
        goto_addr(8);
        apply_stimulus(0, 1, 8'h41, 0, 0, 0, 0, 1, 1);
        step();
        check_output("halt_stalled");
        apply_stimulus(0, 1, 8'h41, 0, 0, 0, 0, 0, 1);
        step();
        check_output("halt");
        check("halt.halted", 32'(bus.halted), 32'd1);
        apply_stimulus(0, 1, 8'h41, 0, 0, 0, 0, 0, 0);
        step();
        check_output("halt_hold");
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check_output("restart");

        // Unconditional jump
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        goto_addr(19);
        apply_stimulus(0, 1, 8'h29, 0, 0, 0, 0, 0, 0);
        step();
        check_output("jump");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(63) != 0);
            apply_stimulus($urandom_range(7) == 0, int'($urandom_range(3)),
                           int'($urandom_range(255)), int'($urandom_range(7)),
                           int'($urandom_range(1)), int'($urandom_range(255)),
                           int'($urandom_range(255)), $urandom_range(3) == 0,
                           $urandom_range(15) == 0);
            step();
            check_output("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Microprogram sequencer for the picoRISC control unit. It holds the 8-bit micro-program counter (uPC) that addresses the control-store ROM and picks the next uPC each cycle from four sources: increment, unconditional jump, conditional jump on a selected flag, or the multiway branch address from the branch-address encoder. It also handles memory-wait stalls and halt. It sits between the control-store ROM (whose microinstruction fields it consumes) and the encoder output, and its uPC is the only source of control-store addresses.

## Interface
- ADDR_W, 8, uPC and branch-address width
- COND_W, 8, number of condition flags (must be power of two; select width = log2(COND_W))
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin microprogram execution from address 0
- mi_br_type  in  2  branch type of current microinstruction: 00 next, 01 jump, 10 conditional jump, 11 multiway
- mi_target  in  ADDR_W  jump/conditional-jump target field
- mi_cond_sel  in  log2(COND_W)  index into cond
- mi_cond_neg  in  1  invert selected condition
- cond  in  COND_W  condition flags from datapath
- mbr_addr  in  ADDR_W  multiway branch address from branch-address encoder
- mem_wait  in  1  memory not ready; freeze uPC
- halt_req  in  1  halt microinstruction / external halt
- upc  out  ADDR_W  current control-store address (registered)
- upc_valid  out  1  high in RUN state
- halted  out  1  high in HALT state

## Operation
- States: IDLE, RUN, HALT.
- Reset (rst_n=0 at clock edge): state=IDLE, upc=0, upc_valid=0, halted=0. Applies from any state, also mid-stall.
- IDLE: upc held at 0. start=1 -> RUN, upc stays 0, so the first executed microinstruction is at address 0.
- RUN, mem_wait=1: upc and state hold. halt_req and branch fields are ignored that cycle.
- RUN, mem_wait=0, halt_req=1: -> HALT, upc holds its value. Halt takes priority over any branch.
- RUN, mem_wait=0, halt_req=0: next upc is chosen by mi_br_type:
  - 00: upc+1, modulo 2^ADDR_W (255 -> 0).
  - 01: mi_target.
  - 10: mi_target if cond[mi_cond_sel] XOR mi_cond_neg, else upc+1.
  - 11: mbr_addr, passed through unchanged. Encoder output 0 is a legal target.
- RUN, start: ignored.
- HALT: upc holds. start=1 -> RUN with upc=0; otherwise stays in HALT.
- Outputs: upc_valid=1 only in RUN. halted=1 only in HALT. Both are decoded from registered state.

## Timing
- Microinstruction fields, cond, mbr_addr, mem_wait and halt_req are combinational functions of the current upc and datapath. All are sampled at the same edge that updates upc.
- Next-address latency: 1 cycle. A branch taken at edge N shows its target on upc after edge N.
- Start latency: start at edge N -> upc_valid=1 after edge N, with upc=0.
- Stall: each cycle with mem_wait=1 adds exactly one cycle. There is no cap on stall length.
- No combinational path from any input to upc, upc_valid or halted.

## Test plan
- Reset mid-run: upc=0x2A in RUN, rst_n=0 for one edge -> upc=0, IDLE, upc_valid=0, halted=0. Assert start=1 during the reset edge -> state is still IDLE.
- Sequential and wrap: start, then mi_br_type=00 for 300 cycles -> upc runs 0,1,…,255,0,…,43 with upc_valid=1 throughout.
- Conditional branch: upc=5, type=10, target=0x40, cond_sel=3, cond=0x08, neg=0 -> upc=0x40. Same with neg=1 -> upc=6. cond=0x00, neg=1 -> upc=0x40.
- Multiway: upc=3, type=11 with mbr_addr=17 -> upc=17. mbr_addr=0 -> upc=0. mbr_addr=49 with mem_wait=1 for 3 cycles -> upc stays 3 for 3 cycles, then becomes 49.
- Halt priority: upc=8, type=01, target=0x41, halt_req=1, mem_wait=0 -> HALT, upc=8, halted=1, upc_valid=0. Same with mem_wait=1 -> stays in RUN with upc=8. In HALT, start=1 -> RUN, upc=0.
- Unconditional jump: upc=19, type=01, target=0x29 -> upc=0x29 after one edge.
